// File: rtl/mem_pkg.sv
// Shared widths, request-kind encoding and pipeline stage payload for the
// memory fill responder.
package mem_pkg;

  localparam int unsigned WORD_W          = 16;
  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DEFAULT_LATENCY = 4;
  localparam int unsigned BLOCK_WORDS     = 8;

  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_RD   = 2'd1,
    REQ_WR   = 2'd2,
    REQ_ERR  = 2'd3
  } req_kind_e;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
  } stage_t;

  // A simultaneous read and write is an error that is serviced as a write.
  function automatic req_kind_e decode_req(input logic rd, input logic wr);
    case ({rd, wr})
      2'b10:   return REQ_RD;
      2'b01:   return REQ_WR;
      2'b11:   return REQ_ERR;
      default: return REQ_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_resp_stage.sv
// One read-return pipeline stage. Data only loads with a valid word, so the
// final stage also serves as the "last returned value" holding register.
module mem_resp_stage
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  stage_t i_stage,
  output stage_t o_stage
);

  stage_t r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage.valid <= i_stage.valid;
      if (i_stage.valid) begin
        r_stage.data <= i_stage.data;
      end
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/mem_fill_responder.sv
// Word-addressed backing store answering cache-fill reads after a fixed
// LATENCY through a fully pipelined return path; writes land immediately.
module mem_fill_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY    = DEFAULT_LATENCY,
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DEPTH      = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     data_in,
  output logic [WORD_W-1:0]     data_out,
  output logic                  data_valid,
  output logic [3:0]            pending,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  logic [WORD_W-1:0] r_mem [DEPTH];

  req_kind_e         w_kind;
  logic              w_rd;
  logic              w_wr;
  logic              w_unused_lsb;
  logic [31:0]       w_word;
  logic [IDX_W-1:0]  w_idx;
  stage_t            w_pipe [LATENCY+1];
  logic              w_ret;
  logic [CNT_W-1:0]  w_pending_nxt;

  logic [CNT_W-1:0]  r_pending;
  logic              r_busy;
  logic              r_err;

  // Request decode and word index (byte LSB dropped, wrap modulo DEPTH).
  assign w_kind       = decode_req(mem_read, mem_write);
  assign w_rd         = (w_kind == REQ_RD);
  assign w_wr         = (w_kind == REQ_WR) || (w_kind == REQ_ERR);
  assign w_unused_lsb = addr[0];
  assign w_word       = 32'(addr[ADDR_WIDTH-1:1]);
  assign w_idx        = IDX_W'(w_word % 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= data_in;
    end
  end

  // Stage 0 is the array sample; reads in flight never see later writes.
  assign w_pipe[0].valid = w_rd;
  assign w_pipe[0].data  = r_mem[w_idx];

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    mem_resp_stage u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_stage (w_pipe[g]),
      .o_stage (w_pipe[g+1])
    );
  end

  assign w_ret = w_pipe[LATENCY].valid;

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_rd && !w_ret) begin
      w_pending_nxt = r_pending + CNT_W'(1);
    end else if (!w_rd && w_ret) begin
      w_pending_nxt = r_pending - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_busy    <= (w_pending_nxt != '0);
      r_err     <= (w_kind == REQ_ERR);
    end
  end

  assign data_out   = w_pipe[LATENCY].data;
  assign data_valid = w_ret;
  assign pending    = r_pending;
  assign busy       = r_busy;
  assign proto_err  = r_err;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder: LATENCY=4 instance plus a LATENCY=1
// instance sharing the same request stream.
module tb_mem_fill_responder;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] din;

  logic [15:0] dout4, dout1;
  logic        dv4, dv1;
  logic [3:0]  pend4, pend1;
  logic        busy4, busy1;
  logic        err4, err1;

  int n_cmp;
  int n_err;

  mem_fill_responder #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .addr(addr),
    .data_in(din), .data_out(dout4), .data_valid(dv4), .pending(pend4),
    .busy(busy4), .proto_err(err4)
  );

  mem_fill_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .addr(addr),
    .data_in(din), .data_out(dout1), .data_valid(dv1), .pending(pend1),
    .busy(busy1), .proto_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    rd = 1'b0; wr = 1'b1; addr = a; din = d;
    step();
    idle();
  endtask

  initial begin
    int dv_cnt;
    int peak;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;

    // Reset state
    step(); step();
    chk("rst_dv",   16'(dv4),   16'd0);
    chk("rst_dout", dout4,      16'd0);
    chk("rst_pend", 16'(pend4), 16'd0);
    chk("rst_busy", 16'(busy4), 16'd0);
    chk("rst_err",  16'(err4),  16'd0);
    rst = 1'b0;

    // Reset in the middle of a 3-read burst
    rd = 1'b1; addr = 16'h0100;
    step(); step();
    chk("burst_pend_pre", 16'(pend4), 16'd2);
    #3 rst = 1'b1;
    #1;
    chk("burst_rst_pend", 16'(pend4), 16'd0);
    chk("burst_rst_busy", 16'(busy4), 16'd0);
    chk("burst_rst_dv",   16'(dv4),   16'd0);
    step();
    rst = 1'b0;
    idle();
    dv_cnt = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (dv4 || dv1) dv_cnt++;
    end
    chk("burst_rst_no_dv", 16'(dv_cnt), 16'd0);
    chk("burst_rst_pend_end", 16'(pend4), 16'd0);

    // Single read
    do_write(16'h0010, 16'hBEEF);
    rd = 1'b1; addr = 16'h0010;
    step();
    idle();
    for (int j = 1; j <= 5; j++) begin
      if (j > 1) step();
      chk($sformatf("single_dv_%0d", j),   16'(dv4),   (j == 4) ? 16'd1 : 16'd0);
      chk($sformatf("single_pend_%0d", j), 16'(pend4), (j <= 4) ? 16'd1 : 16'd0);
    end
    chk("single_dout_hold", dout4, 16'hBEEF);
    chk("single_busy_end", 16'(busy4), 16'd0);

    // Fill burst of one block
    for (int i = 0; i < BLOCK_WORDS; i++)
      do_write(16'(16'h1000 + 2 * i), 16'(16'hA000 + i));
    peak = 0;
    for (int j = 1; j <= 12; j++) begin
      if (j <= BLOCK_WORDS) begin
        rd = 1'b1; addr = 16'(16'h1000 + 2 * (j - 1));
      end else begin
        idle();
      end
      step();
      if (int'(pend4) > peak) peak = int'(pend4);
      chk($sformatf("fill_dv_%0d", j), 16'(dv4), (j >= 4 && j <= 11) ? 16'd1 : 16'd0);
      chk($sformatf("fill_pend_%0d", j), 16'(pend4),
          (j <= 3) ? 16'(j) : (j <= 8) ? 16'd4 : 16'(12 - j));
      if (j >= 4 && j <= 11)
        chk($sformatf("fill_dout_%0d", j), dout4, 16'(16'hA000 + j - 4));
    end
    idle();
    chk("fill_peak", 16'(peak), 16'd4);

    // Write behind an in-flight read
    do_write(16'h0020, 16'h1111);
    for (int j = 1; j <= 7; j++) begin
      idle();
      if (j == 1 || j == 3) begin
        rd = 1'b1; addr = 16'h0020;
      end else if (j == 2) begin
        wr = 1'b1; addr = 16'h0020; din = 16'h2222;
      end
      step();
      chk($sformatf("inflight_dv_%0d", j), 16'(dv4), (j == 4 || j == 6) ? 16'd1 : 16'd0);
      if (j == 4) chk("inflight_old", dout4, 16'h1111);
      if (j == 6) chk("inflight_new", dout4, 16'h2222);
    end
    idle();

    // Conflicting read+write
    rd = 1'b1; wr = 1'b1; addr = 16'h0030; din = 16'h5555;
    step();
    idle();
    chk("conf_err4", 16'(err4), 16'd1);
    chk("conf_err1", 16'(err1), 16'd1);
    chk("conf_pend", 16'(pend4), 16'd0);
    dv_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      if (dv4 || dv1) dv_cnt++;
      step();
      if (j == 0) chk("conf_err_clear", 16'(err4), 16'd0);
    end
    chk("conf_no_dv", 16'(dv_cnt), 16'd0);
    rd = 1'b1; addr = 16'h0030;
    step();
    idle();
    step(); step(); step();
    chk("conf_read_dv",   16'(dv4), 16'd1);
    chk("conf_read_data", dout4,    16'h5555);

    // Odd address on both latencies
    do_write(16'h0010, 16'h7777);
    rd = 1'b1; addr = 16'h0011;
    step();
    idle();
    for (int j = 1; j <= 5; j++) begin
      if (j > 1) step();
      chk($sformatf("odd_dv1_%0d", j), 16'(dv1), (j == 1) ? 16'd1 : 16'd0);
      chk($sformatf("odd_dv4_%0d", j), 16'(dv4), (j == 4) ? 16'd1 : 16'd0);
      if (j == 1) chk("odd_dout1", dout1, 16'h7777);
      if (j == 4) chk("odd_dout4", dout4, 16'h7777);
    end
    chk("odd_pend1_end", 16'(pend1), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Main-memory responder on the far end of the cache-fill read interface.
- Accepts one word read or write request per cycle and returns each read word exactly LATENCY cycles after issue, with a one-cycle data_valid pulse.
- Fully pipelined: a fill engine can issue 8 back-to-back reads, one per 2-byte block offset, and receives 8 consecutive valid words.
- Sits between the I/D cache fill FSMs, behind the arbiter, and the word-addressed backing store.

Parameters:
- LATENCY, 4, cycles from the read-issue edge to data_valid; legal range 1..15.
- ADDR_WIDTH, 16, byte address width; word index is addr[ADDR_WIDTH-1:1].
- DEPTH, 32768, number of 16-bit words in the backing array.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  read request, sampled every cycle.
- mem_write  in  1  write request, sampled every cycle.
- addr  in  16  byte address; addr[0] is ignored.
- data_in  in  16  write data.
- data_out  out  16  read data; meaningful only while data_valid=1.
- data_valid  out  1  one-cycle pulse per returned read word.
- pending  out  4  count of reads issued but not yet returned.
- busy  out  1  high when pending != 0.
- proto_err  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (async, any time, including mid-burst):
  - Clears every pipeline valid bit, pending=0, data_out=0, data_valid=0, busy=0, proto_err=0.
  - All in-flight reads are discarded and never returned.
  - Array contents are not cleared.
- Read issue at edge t:
  - Array word addr[15:1] is sampled into pipeline stage 1 at edge t.
  - The word moves one stage per cycle.
  - data_valid=1 and data_out=word during the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after the issue cycle.
- Write issue at edge t:
  - Array is written at edge t.
  - A read issued at t+1 or later returns the new value.
  - In-flight reads keep the value sampled at their own issue edge; no forwarding into the pipeline.
- Simultaneous mem_read and mem_write:
  - Treated as a write only; the read is dropped and never returned.
  - proto_err pulses for one cycle.
- Throughput and ordering:
  - A new read is accepted every cycle with no stall; reads return in issue order.
  - Successive reads at consecutive cycles produce consecutive data_valid cycles.
- pending counter:
  - +1 on an accepted read; -1 when data_valid is asserted.
  - Both in the same cycle: unchanged.
  - Maximum value is LATENCY; it never wraps.
- data_out when data_valid=0: holds the last returned value (0 after reset).
- Address handling:
  - addr[0]=1 is silently aligned down to the even address.
  - Addresses beyond DEPTH wrap modulo DEPTH.
- Pipeline structure: shift register of LATENCY stages, each stage holding {valid, data[15:0]}; there is no controller state machine beyond the pipeline valids and pending.

Decomposition:
- Shared package `mem_pkg`:
  - WORD_W=16, ADDR_W=16, DEFAULT_LATENCY=4, BLOCK_WORDS=8.
  - Request-kind encoding: IDLE/RD/WR/ERR.
- Sub-module `mem_resp_stage`: one {valid, data} dff stage with async reset.
  - Instantiated LATENCY times by a generate loop.
- Top level owns the array, the request decode, and the pending counter.

Test Plan:
- Reset during burst: issue 3 reads, assert rst at cycle 2 -> data_valid stays 0 forever after; pending=0; busy=0.
- Single read: write 0xBEEF to 0x0010, then read 0x0010 at cycle t -> data_valid=1, data_out=0xBEEF at t+4 only; pending=1 for cycles t+1..t+4, then 0.
- Fill burst: preload words 0x1000..0x100E with 0xA000+i, then issue reads at 0x1000,0x1002,...,0x100E on 8 consecutive cycles -> 8 consecutive data_valid cycles with values 0xA000..0xA007 in order; pending peaks at 4.
- Write during in-flight read: read 0x0020 (old 0x1111) at t, write 0x2222 to 0x0020 at t+1, read 0x0020 at t+2 -> returns 0x1111 at t+4 and 0x2222 at t+6.
- Conflict: mem_read=mem_write=1, addr=0x0030, data_in=0x5555 -> proto_err pulse; no data_valid; a later read of 0x0030 returns 0x5555.
- Odd address and latency: read 0x0011 after writing 0x0010=0x7777 -> returns 0x7777; repeat with LATENCY=1 -> data_valid in the cycle after issue.
